// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side signal bundle for alu_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters plus the ALU.
interface alu_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_r_i_s;
    logic [3*NUM_REQ-1:0]  req_funct3;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [32*NUM_REQ-1:0] rsp_data;
    logic [31:0]           alu_a;
    logic [31:0]           alu_b;
    logic                  alu_in_valid;
    logic                  alu_r_i_s;
    logic [2:0]            alu_funct3;
    logic [31:0]           alu_out;
    logic                  alu_out_valid;
    logic                  proto_err;

    modport master (
        output req_valid, req_r_i_s, req_funct3, req_a, req_b, rsp_ready,
               alu_out, alu_out_valid,
        input  req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_in_valid,
               alu_r_i_s, alu_funct3, proto_err
    );

    modport slave (
        input  req_valid, req_r_i_s, req_funct3, req_a, req_b, rsp_ready,
               alu_out, alu_out_valid,
        output req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_in_valid,
               alu_r_i_s, alu_funct3, proto_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one pipelined ALU between NUM_REQ requesters, routing results back by tag.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module alu_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ALU_LAT = 2
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    busy_q;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    logic                  grant_vld;
    logic [IdxW-1:0]       grant_idx;

    logic [31:0]           alu_a_q, alu_b_q;
    logic                  alu_in_valid_q;
    logic                  alu_r_i_s_q, op_r_i_s_q;
    logic [2:0]            alu_funct3_q, op_funct3_q;
    logic [IdxW-1:0]       issue_idx_q;

    logic                  tag_v_q [ALU_LAT];
    logic [IdxW-1:0]       tag_i_q [ALU_LAT];

    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [32*NUM_REQ-1:0] rsp_data_q;
    logic [NUM_REQ-1:0]    rsp_take;
    logic                  proto_err_q;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [IdxW-1:0]       ptr_q;
`endif

    assign eligible = bus.req_valid & ~busy_q;
    assign rsp_take = rsp_valid_q & bus.rsp_ready;

    // Descending scan: the last hit assigned is the highest-priority candidate.
    always_comb begin : p_grant
        logic [IdxW-1:0] idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            idx = IdxW'(k - 1);
`else
            idx = IdxW'((32'(ptr_q) + k) % NUM_REQ);
`endif
            if (eligible[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
        grant = '0;
        if (grant_vld) grant[grant_idx] = 1'b1;
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IdxW'(NUM_REQ - 1);
        end else if (grant_vld) begin
            ptr_q <= grant_idx;
        end
    end
`endif

    // Operands go out one cycle after the handshake; op fields a further cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_in_valid_q <= 1'b0;
            op_r_i_s_q     <= 1'b0;
            op_funct3_q    <= '0;
            issue_idx_q    <= '0;
            alu_r_i_s_q    <= 1'b0;
            alu_funct3_q   <= '0;
        end else begin
            alu_in_valid_q <= grant_vld;
            if (grant_vld) begin
                alu_a_q     <= bus.req_a[32*grant_idx +: 32];
                alu_b_q     <= bus.req_b[32*grant_idx +: 32];
                op_r_i_s_q  <= bus.req_r_i_s[grant_idx];
                op_funct3_q <= bus.req_funct3[3*grant_idx +: 3];
                issue_idx_q <= grant_idx;
            end
            if (alu_in_valid_q) begin
                alu_r_i_s_q  <= op_r_i_s_q;
                alu_funct3_q <= op_funct3_q;
            end
        end
    end

    // Tag stage k mirrors the ALU stage k+1 cycles after alu_in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(ALU_LAT); k++) begin
                tag_v_q[k] <= 1'b0;
                tag_i_q[k] <= '0;
            end
        end else begin
            tag_v_q[0] <= alu_in_valid_q;
            tag_i_q[0] <= issue_idx_q;
            for (int k = 1; k < int'(ALU_LAT); k++) begin
                tag_v_q[k] <= tag_v_q[k-1];
                tag_i_q[k] <= tag_i_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (grant[i]) begin
                    busy_q[i] <= 1'b1;
                end else if (rsp_take[i]) begin
                    busy_q[i] <= 1'b0;
                end
                if (tag_v_q[ALU_LAT-1] && tag_i_q[ALU_LAT-1] == IdxW'(i)) begin
                    rsp_valid_q[i]         <= 1'b1;
                    rsp_data_q[32*i +: 32] <= bus.alu_out;
                end else if (rsp_take[i]) begin
                    rsp_valid_q[i] <= 1'b0;
                end
            end
            if (bus.alu_out_valid != tag_v_q[ALU_LAT-1]) proto_err_q <= 1'b1;
        end
    end

    assign bus.req_ready    = grant;
    assign bus.alu_a        = alu_a_q;
    assign bus.alu_b        = alu_b_q;
    assign bus.alu_in_valid = alu_in_valid_q;
    assign bus.alu_r_i_s    = alu_r_i_s_q;
    assign bus.alu_funct3   = alu_funct3_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.proto_err    = proto_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a two-stage ALU model whose op fields
// are sampled one cycle after the operands.
module tb_alu_arbiter;
    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ALU_LAT = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    alu_arbiter #(.NUM_REQ(NUM_REQ), .ALU_LAT(ALU_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ALU model: operands registered, op applied in the second stage.
    logic        s1_valid, m_valid, force_valid;
    logic [31:0] s1_a, s1_b, m_out;

    function automatic logic [31:0] alu_fn(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        case (f3)
            3'b000:  return a + b;
            3'b001:  return a << b[4:0];
            3'b100:  return a ^ b;
            3'b110:  return a | b;
            3'b111:  return a & b;
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            m_valid  <= 1'b0;
            m_out    <= '0;
        end else begin
            s1_valid <= bus.alu_in_valid;
            s1_a     <= bus.alu_a;
            s1_b     <= bus.alu_b;
            m_valid  <= s1_valid;
            m_out    <= alu_fn(bus.alu_funct3, s1_a, s1_b);
        end
    end

    assign bus.alu_out_valid = m_valid | force_valid;
    assign bus.alu_out       = m_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] f3, input logic r);
        bus.req_a[32*i +: 32]  = a;
        bus.req_b[32*i +: 32]  = b;
        bus.req_funct3[3*i +: 3] = f3;
        bus.req_r_i_s[i]       = r;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.rsp_ready  = '0;
        force_valid    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = '0;
        bus.req_r_i_s  = '0;
        bus.req_funct3 = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.rsp_ready  = '0;
        force_valid    = 1'b0;
        rst_n          = 1'b0;
        tick();
        tick();
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_alu_in_valid", 32'(bus.alu_in_valid), 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_proto_err", 32'(bus.proto_err), 0);
        rst_n = 1'b1;
        tick();

        // 1: single add 5+7
        set_req(0, 32'd5, 32'd7, 3'b000, 1'b1);
        bus.req_valid = 2'b01;
        #1 check("t1_ready", 32'(bus.req_ready), 32'b01);
        tick();
        bus.req_valid = 2'b00;
        check("t1_in_valid", 32'(bus.alu_in_valid), 1);
        check("t1_alu_a", bus.alu_a, 5);
        check("t1_alu_b", bus.alu_b, 7);
        check("t1_ris_early", 32'(bus.alu_r_i_s), 0);
        tick();
        check("t1_in_valid_idle", 32'(bus.alu_in_valid), 0);
        check("t1_alu_a_hold", bus.alu_a, 5);
        check("t1_ris", 32'(bus.alu_r_i_s), 1);
        tick();
        check("t1_rsp_not_yet", 32'(bus.rsp_valid), 0);
        tick();
        check("t1_rsp_valid", 32'(bus.rsp_valid), 32'b01);
        check("t1_rsp_data", bus.rsp_data[31:0], 12);
        bus.req_valid = 2'b01;
        #1 check("t1_busy_no_grant", 32'(bus.req_ready), 0);
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b01;
        tick();
        check("t1_rsp_cleared", 32'(bus.rsp_valid), 0);

        // 2: both requesters saturating, responses taken immediately
        do_reset();
        set_req(0, 32'd3, 32'd4, 3'b000, 1'b1);
        set_req(1, 32'd2, 32'd3, 3'b001, 1'b0);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        for (int k = 0; k < 15; k++) begin
            #1;
            check($sformatf("t2_grant_%0d", k), 32'(bus.req_ready),
                  (k % 5 == 0) ? 32'b01 : (k % 5 == 1) ? 32'b10 : 32'b00);
            check($sformatf("t2_rsp_%0d", k), 32'(bus.rsp_valid),
                  (k >= 4 && k % 5 == 4) ? 32'b01 : (k >= 5 && k % 5 == 0) ? 32'b10 : 32'b00);
            if (k >= 4 && k % 5 == 4) check("t2_data0", bus.rsp_data[31:0], 7);
            if (k >= 5 && k % 5 == 0) check("t2_data1", bus.rsp_data[63:32], 16);
            tick();
        end
        bus.req_valid = 2'b00;
        check("t2_proto_err", 32'(bus.proto_err), 0);

        // 3: back-to-back issue from different requesters
        do_reset();
        set_req(0, 32'hF0, 32'h3C, 3'b111, 1'b0);
        set_req(1, 32'd1, 32'd4, 3'b001, 1'b1);
        bus.req_valid = 2'b11;
        #1 check("t3_grant0", 32'(bus.req_ready), 32'b01);
        tick();
        bus.req_valid = 2'b10;
        #1 check("t3_grant1", 32'(bus.req_ready), 32'b10);
        tick();
        bus.req_valid = 2'b00;
        check("t3_funct3_first", 32'(bus.alu_funct3), 32'b111);
        tick();
        check("t3_funct3_second", 32'(bus.alu_funct3), 32'b001);
        tick();
        check("t3_rsp0_valid", 32'(bus.rsp_valid), 32'b01);
        check("t3_rsp0_data", bus.rsp_data[31:0], 32'h30);
        tick();
        check("t3_rsp1_valid", 32'(bus.rsp_valid), 32'b11);
        check("t3_rsp1_data", bus.rsp_data[63:32], 32'h10);
        bus.rsp_ready = 2'b11;
        tick();
        check("t3_drained", 32'(bus.rsp_valid), 0);
        check("t3_proto_err", 32'(bus.proto_err), 0);

        // 4: response back-pressure blocks regrant
        do_reset();
        set_req(0, 32'd9, 32'd1, 3'b000, 1'b1);
        bus.req_valid = 2'b01;
        #1 check("t4_grant", 32'(bus.req_ready), 32'b01);
        tick();
        tick();
        tick();
        tick();
        check("t4_rsp_valid", 32'(bus.rsp_valid), 32'b01);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("t4_data_%0d", k), bus.rsp_data[31:0], 10);
            check($sformatf("t4_ready_%0d", k), 32'(bus.req_ready), 0);
            tick();
        end
        bus.rsp_ready = 2'b01;
        #1 check("t4_same_cycle", 32'(bus.req_ready), 0);
        tick();
        check("t4_regrant", 32'(bus.req_ready), 32'b01);
        check("t4_rsp_cleared", 32'(bus.rsp_valid), 0);
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;

        // 5: spurious alu_out_valid
        do_reset();
        force_valid = 1'b1;
        tick();
        force_valid = 1'b0;
        check("t5_proto_err", 32'(bus.proto_err), 1);
        tick();
        tick();
        tick();
        check("t5_proto_sticky", 32'(bus.proto_err), 1);
        check("t5_rsp_valid", 32'(bus.rsp_valid), 0);

        // 6: reset with one response held and one op in flight
        do_reset();
        check("t6_proto_cleared", 32'(bus.proto_err), 0);
        set_req(0, 32'd1, 32'd1, 3'b000, 1'b1);
        set_req(1, 32'd2, 32'd2, 3'b000, 1'b1);
        bus.req_valid = 2'b11;
        tick();
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
        check("t6_rsp_before", 32'(bus.rsp_valid), 32'b01);
        rst_n = 1'b0;
        #1 check("t6_rsp_async_clear", 32'(bus.rsp_valid), 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("t6_no_late_%0d", k), 32'(bus.rsp_valid), 0);
        end
        check("t6_proto_err", 32'(bus.proto_err), 0);
        bus.req_valid = 2'b11;
        #1 check("t6_first_grant", 32'(bus.req_ready), 32'b01);
        bus.req_valid = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
